wb_regfile: RTL
===============

Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: performs the writeback select and holds the 2**W x B general-purpose register file.
- Provides two combinational read ports to the ID stage.
- Provides a debug dump sequencer that streams all registers to the debug unit over a valid/ready handshake.
- Sits after the MEM/WB latch; its outputs feed ID-stage operand fetch and the forwarding unit.

Parameters:
- B, 32, data width.
- W, 5, register address width; depth = 2**W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ena  in  1  writeback enable (pipeline stall gate); 0 blocks register writes.
- read_data_in  in  B  memory load data from MEM/WB.
- alu_result_in  in  B  ALU result from MEM/WB.
- mux_RegDst_in  in  W  destination register index.
- wb_RegWrite_in  in  1  write request.
- wb_MemtoReg_in  in  1  1 selects read_data_in, 0 selects alu_result_in.
- wb_data_out  out  B  selected writeback value (combinational), for forwarding.
- rs_addr  in  W  read port A index.
- rt_addr  in  W  read port B index.
- rs_data  out  B  read port A data (combinational).
- rt_data  out  B  read port B data (combinational).
- dump_start  in  1  single-cycle request to stream all registers.
- dump_ready  in  1  debug unit accepts the current word.
- dump_valid  out  1  dump_data/dump_addr are valid.
- dump_addr  out  W  index of the word presented.
- dump_data  out  B  register contents being presented.
- dump_busy  out  1  sequencer not IDLE.
- dump_done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers cleared to 0.
  - FSM forced to IDLE.
  - dump_valid, dump_addr, dump_data, dump_busy, dump_done = 0.
  - Reset asserted mid-dump aborts the dump; no dump_done is produced.
- Writeback select: wb_data_out = wb_MemtoReg_in ? read_data_in : alu_result_in.
- Write:
  - Occurs at posedge when ena=1, wb_RegWrite_in=1 and mux_RegDst_in != 0.
  - Latency 1 cycle: the new value is visible on the read ports the following cycle.
- Register 0: reads always return 0; writes to register 0 are dropped silently.
- Reads are combinational: rs_data = reg[rs_addr], rt_data = reg[rt_addr], subject to the register-0 rule and WB_BYPASS_EN.
- Dump FSM, states IDLE, SEND, DONE:
  - IDLE: on dump_start=1, go to SEND with idx=0 and capture dump_data<=reg[0], dump_addr<=0, dump_valid<=1.
  - SEND, dump_valid=1 and dump_ready=0: hold dump_data and dump_addr stable (captured words are not updated by later writes).
  - SEND, dump_valid & dump_ready, idx < 2**W-1: increment idx and capture reg[idx+1] in the same edge; back-to-back transfers at 1 word/cycle.
  - SEND, dump_valid & dump_ready, idx = 2**W-1: dump_valid<=0, go to DONE.
  - DONE: dump_done=1 for exactly one cycle, then IDLE.
  - dump_busy=1 in SEND and DONE.
  - dump_start is ignored in SEND and DONE.
  - Captured words reflect register contents at the capture edge. A write to the register being captured in the same cycle is not included in that capture.
  - Writes are permitted during a dump.
- Index arithmetic: idx is W bits and does not wrap beyond 2**W-1, because termination takes priority over increment.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: if a write is occurring this cycle and rs_addr or rt_addr equals mux_RegDst_in (nonzero), that port returns wb_data_out combinationally (write-then-read in the same cycle). Dump capture is unaffected.
- Undefined: read ports return the stored value; the new value appears the next cycle.

Decomposition:
- Shared pipeline package: B/W defaults, register-0 index constant, dump FSM state encoding (IDLE=2'd0, SEND=2'd1, DONE=2'd2).
- One natural sub-module: wb_dump_seq (FSM, idx counter, capture register, handshake outputs). It reads the register array through an index/data pair.

Test Plan:
- Reset, then write alu_result_in=0xDEADBEEF to r5 with MemtoReg=0, ena=1 -> next cycle rs_addr=5 gives 0xDEADBEEF; wb_data_out=0xDEADBEEF during the write cycle.
- MemtoReg=1, read_data_in=0x12345678, dest r0; also dest r7 with ena=0 -> r0 and r7 both read 0.
- With WB_BYPASS_EN: write 0xA5A5A5A5 to r9 while rt_addr=9 -> rt_data=0xA5A5A5A5 the same cycle. Without the macro -> old value (0) that cycle, 0xA5A5A5A5 the next cycle.
- Preload r1..r31 with value=index; pulse dump_start with dump_ready=1 -> 32 consecutive valid beats, addr 0..31, data 0..31; dump_done pulses one cycle after the last beat; dump_busy spans beat 1 to done.
- Dump with dump_ready held 0 for 3 cycles on addr 4 while r4 is written 0xFFFF -> dump_data holds 4 throughout; a dump_start pulse during SEND is ignored.
- Assert reset at addr 10 mid-dump -> dump_valid/busy drop to 0 immediately; all registers read 0; no dump_done.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared defaults, register-0 index and dump FSM encoding
package wb_regfile_pkg;

    localparam int B_DEF    = 32;
    localparam int W_DEF    = 5;
    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_SEND = 2'd1,
        DUMP_DONE = 2'd2
    } dump_state_e;

endpackage

// File: rtl/wb_dump_seq.sv
// rtl/wb_dump_seq.sv - register dump sequencer streaming the register file over valid/ready
module wb_dump_seq
    import wb_regfile_pkg::*;
#(
    parameter int B = B_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         dump_start,
    input  logic         dump_ready,
    output logic [W-1:0] rd_idx,
    input  logic [B-1:0] rd_data,
    output logic         dump_valid,
    output logic [W-1:0] dump_addr,
    output logic [B-1:0] dump_data,
    output logic         dump_busy,
    output logic         dump_done
);

    localparam logic [W-1:0] LAST_IDX = '1;

    dump_state_e  state_q, state_d;
    logic [W-1:0] idx_q, idx_d;
    logic [B-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         accept;

    assign accept = valid_q & dump_ready;

    // State and capture registers; reset aborts any dump in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= DUMP_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Next state and next capture; termination wins over increment so idx never wraps
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        case (state_q)
            DUMP_IDLE: begin
                if (dump_start) begin
                    state_d = DUMP_SEND;
                    idx_d   = '0;
                    data_d  = rd_data;
                    valid_d = 1'b1;
                end
            end
            DUMP_SEND: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        valid_d = 1'b0;
                        state_d = DUMP_DONE;
                    end else begin
                        idx_d  = idx_q + W'(1);
                        data_d = rd_data;
                    end
                end
            end
            DUMP_DONE: begin
                state_d = DUMP_IDLE;
            end
            default: begin
                state_d = DUMP_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Outputs: read index for the next capture plus handshake/status signals
    always_comb begin
        rd_idx     = (state_q == DUMP_IDLE) ? W'(REG_ZERO) : idx_q + W'(1);
        dump_valid = valid_q;
        dump_addr  = idx_q;
        dump_data  = data_q;
        dump_busy  = (state_q != DUMP_IDLE);
        dump_done  = (state_q == DUMP_DONE);
    end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback select, register file, read ports, dump (optional WB_BYPASS_EN)
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int B = B_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ena,
    input  logic [B-1:0] read_data_in,
    input  logic [B-1:0] alu_result_in,
    input  logic [W-1:0] mux_RegDst_in,
    input  logic         wb_RegWrite_in,
    input  logic         wb_MemtoReg_in,
    output logic [B-1:0] wb_data_out,
    input  logic [W-1:0] rs_addr,
    input  logic [W-1:0] rt_addr,
    output logic [B-1:0] rs_data,
    output logic [B-1:0] rt_data,
    input  logic         dump_start,
    input  logic         dump_ready,
    output logic         dump_valid,
    output logic [W-1:0] dump_addr,
    output logic [B-1:0] dump_data,
    output logic         dump_busy,
    output logic         dump_done
);

    localparam int DEPTH = 1 << W;

    logic [B-1:0] regs_q [DEPTH];
    logic         wr_en;
    logic [B-1:0] wr_data_d;
    logic [W-1:0] dump_rd_idx;
    logic [B-1:0] dump_rd_data;
    logic [B-1:0] rs_stored;
    logic [B-1:0] rt_stored;

    assign wb_data_out = wb_MemtoReg_in ? read_data_in : alu_result_in;
    assign wr_data_d   = wb_data_out;
    assign wr_en       = ena & wb_RegWrite_in & (mux_RegDst_in != W'(REG_ZERO));

    // Register array; writes to register 0 are filtered out by wr_en
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[mux_RegDst_in] <= wr_data_d;
        end
    end

    // Stored-value reads, register 0 forced to zero
    always_comb begin
        rs_stored = (rs_addr == W'(REG_ZERO)) ? '0 : regs_q[rs_addr];
        rt_stored = (rt_addr == W'(REG_ZERO)) ? '0 : regs_q[rt_addr];
    end

`ifdef WB_BYPASS_EN
    // Read ports with same-cycle write-then-read forwarding
    always_comb begin
        rs_data = (wr_en && (rs_addr == mux_RegDst_in)) ? wb_data_out : rs_stored;
        rt_data = (wr_en && (rt_addr == mux_RegDst_in)) ? wb_data_out : rt_stored;
    end
`else
    // Read ports return stored contents; a write shows up the next cycle
    always_comb begin
        rs_data = rs_stored;
        rt_data = rt_stored;
    end
`endif

    // Dump captures the stored value, never the bypassed one
    assign dump_rd_data = (dump_rd_idx == W'(REG_ZERO)) ? '0 : regs_q[dump_rd_idx];

    wb_dump_seq #(
        .B(B),
        .W(W)
    ) u_dump_seq (
        .clk        (clk),
        .reset      (reset),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .rd_idx     (dump_rd_idx),
        .rd_data    (dump_rd_data),
        .dump_valid (dump_valid),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

endmodule
